// File: rtl/vram_arbiter_if.sv
// CPU-side bus of the VRAM arbiter: a request/acknowledge handshake carrying
// write data out and read data back.
interface vram_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) ();
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches always win with fixed latency, the CPU takes free slots.
// Define VRAM_BLANK_ONLY_EN to restrict CPU grants to horizontal/vertical blanking.
module vram_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int RAM_LAT = 1,
   parameter int STALL_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               hblank,
   input  logic               vblank,
   input  logic               vid_req,
   input  logic [ADDR_W-1:0]  vid_addr,
   output logic               vid_valid,
   output logic [DATA_W-1:0]  vid_data,
   vram_arbiter_if.slave      cpu,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic               ram_we,
   output logic [DATA_W-1:0]  ram_wdata,
   input  logic [DATA_W-1:0]  ram_rdata,
   output logic [STALL_W-1:0] stall_max
);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] RD_WAIT = 1'b1;

   logic [0:0]         state;
   logic               cpu_window;
   logic               vid_grant;
   logic               cpu_grant;
   logic [RAM_LAT-1:0] pipe_vid;
   logic [RAM_LAT-1:0] pipe_rd;
   logic               vid_out;
   logic               rd_out;
   logic [STALL_W-1:0] stall_cnt;
   logic [STALL_W-1:0] stall_nxt;
   logic [STALL_W-1:0] running_max;
   logic               vblank_q;
   logic               vblank_rise;

`ifdef VRAM_BLANK_ONLY_EN
   assign cpu_window = hblank | vblank;
`else
   assign cpu_window = 1'b1 | hblank;  // blanking does not gate the CPU in this build
`endif

   assign vid_grant = vid_req;
   assign cpu_grant = ~vid_req & cpu.req & (state == IDLE) & cpu_window;
   assign vid_out   = pipe_vid[RAM_LAT-1];
   assign rd_out    = pipe_rd[RAM_LAT-1];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_wdata <= '0;
      end else begin
         ram_we <= cpu_grant & cpu.we;
         if (vid_grant) begin
            ram_addr <= vid_addr;
         end else if (cpu_grant) begin
            ram_addr  <= cpu.addr;
            ram_wdata <= cpu.wdata;
         end
      end
   end

   // Tags ride alongside the RAM access so the output stage knows who owns ram_rdata.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_vid <= '0;
         pipe_rd  <= '0;
      end else begin
         pipe_vid[0] <= vid_grant;
         pipe_rd[0]  <= cpu_grant & ~cpu.we;
         for (int i = 1; i < RAM_LAT; i++) begin
            pipe_vid[i] <= pipe_vid[i-1];
            pipe_rd[i]  <= pipe_rd[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         vid_valid <= 1'b0;
         vid_data  <= '0;
         cpu.ack   <= 1'b0;
         cpu.rdata <= '0;
      end else begin
         vid_valid <= vid_out;
         if (vid_out) begin
            vid_data <= ram_rdata;
         end
         cpu.ack <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_grant) begin
                  if (cpu.we) begin
                     cpu.ack <= 1'b1;
                  end else begin
                     state <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               // Back to IDLE with the ack, so a request still high then counts as new.
               if (rd_out) begin
                  cpu.ack   <= 1'b1;
                  cpu.rdata <= ram_rdata;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end

   // NOTE: assign a default first so every path drives stall_nxt and no latch is inferred.
   always_comb begin
      stall_nxt = stall_cnt;
      if (cpu_grant) begin
         stall_nxt = '0;
      end else if (cpu.req && (stall_cnt != {STALL_W{1'b1}})) begin
         stall_nxt = stall_cnt + 1'b1;
      end
   end

   assign vblank_rise = vblank & ~vblank_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         vblank_q    <= 1'b0;
         stall_cnt   <= '0;
         running_max <= '0;
         stall_max   <= '0;
      end else begin
         vblank_q  <= vblank;
         stall_cnt <= stall_nxt;
         if (vblank_rise) begin
            stall_max   <= running_max;
            running_max <= '0;
         end else if (stall_nxt > running_max) begin
            running_max <= stall_nxt;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a behavioural VRAM plus queues of expected
// video and CPU returns, compared when the DUT raises vid_valid / cpu ack.
module tb_vram_arbiter;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 8;
   localparam int RAM_LAT = 1;
   localparam int STALL_W = 8;
`ifdef VRAM_BLANK_ONLY_EN
   localparam logic HB_REST = 1'b1;
`else
   localparam logic HB_REST = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] cyc;
      logic [7:0]  data;
      logic        rd;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               hblank;
   logic               vblank;
   logic               vid_req;
   logic [ADDR_W-1:0]  vid_addr;
   logic               vid_valid;
   logic [DATA_W-1:0]  vid_data;
   logic [ADDR_W-1:0]  ram_addr;
   logic               ram_we;
   logic [DATA_W-1:0]  ram_wdata;
   logic [DATA_W-1:0]  ram_rdata;
   logic [STALL_W-1:0] stall_max;

   logic [7:0] mem [0:65535];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   exp_t       vid_q[$];
   exp_t       cpu_q[$];
   exp_t       ve;
   exp_t       ce;
   logic [7:0] pre_4004;

   vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_bus ();

   vram_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .RAM_LAT(RAM_LAT),
      .STALL_W(STALL_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .hblank   (hblank),
      .vblank   (vblank),
      .vid_req  (vid_req),
      .vid_addr (vid_addr),
      .vid_valid(vid_valid),
      .vid_data (vid_data),
      .cpu      (cpu_bus),
      .ram_addr (ram_addr),
      .ram_we   (ram_we),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .stall_max(stall_max)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // VRAM model: data for the address granted in cycle t is on ram_rdata in cycle t+RAM_LAT.
   initial begin
      for (int a = 0; a < 65536; a++) begin
         mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
      end
   end
   always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
   assign ram_rdata = mem[ram_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_vid(input logic [15:0] a);
      exp_t e;
      e.cyc  = cyc + RAM_LAT + 1;
      e.data = mem[a];
      e.rd   = 1'b0;
      vid_q.push_back(e);
   endtask

   task automatic vid_burst(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         vid_req  = 1'b1;
         vid_addr = base + 16'(i);
         push_vid(vid_addr);
         step();
      end
      vid_req = 1'b0;
   endtask

   // Request held until ack; delay is the bench's expected request-to-ack cycle count.
   task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rdata_exp, input int delay);
      exp_t e;
      int   budget;
      cpu_bus.req   = 1'b1;
      cpu_bus.we    = we;
      cpu_bus.addr  = addr;
      cpu_bus.wdata = wdata;
      e.cyc  = cyc + delay;
      e.data = rdata_exp;
      e.rd   = ~we;
      cpu_q.push_back(e);
      budget = delay + 8;
      do begin
         step();
         budget--;
      end while (!cpu_bus.ack && budget > 0);
      check("cpu_ack_seen", {31'b0, cpu_bus.ack}, 32'd1);
      cpu_bus.req = 1'b0;
   endtask

   task automatic vblank_pulse(input string tag, input logic [7:0] exp);
      vblank = 1'b1;
      step();
      vblank = 1'b0;
      check(tag, stall_max, exp);
   endtask

   task automatic check_rst(input string pfx);
      check({pfx, "vid_valid"}, vid_valid, 0);
      check({pfx, "cpu_ack"}, cpu_bus.ack, 0);
      check({pfx, "ram_we"}, ram_we, 0);
      check({pfx, "ram_addr"}, ram_addr, 0);
      check({pfx, "ram_wdata"}, ram_wdata, 0);
      check({pfx, "vid_data"}, vid_data, 0);
      check({pfx, "cpu_rdata"}, cpu_bus.rdata, 0);
      check({pfx, "stall_max"}, stall_max, 0);
   endtask

   always @(negedge clk) begin
      if (vid_valid) begin
         if (vid_q.size() == 0) begin
            check("vid_extra", {31'b0, vid_valid}, 32'd0);
         end else begin
            ve = vid_q.pop_front();
            check("vid_cycle", cyc, ve.cyc);
            check("vid_data", vid_data, ve.data);
         end
      end
      if (cpu_bus.ack) begin
         if (cpu_q.size() == 0) begin
            check("cpu_extra", {31'b0, cpu_bus.ack}, 32'd0);
         end else begin
            ce = cpu_q.pop_front();
            check("cpu_ack_cycle", cyc, ce.cyc);
            if (ce.rd) check("cpu_rdata", cpu_bus.rdata, ce.data);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // NOTE: stimulus uses blocking assignments, applied 1 time unit after the edge.
      reset         = 1'b1;
      hblank        = HB_REST;
      vblank        = 1'b0;
      vid_req       = 1'b0;
      vid_addr      = '0;
      cpu_bus.req   = 1'b0;
      cpu_bus.we    = 1'b0;
      cpu_bus.addr  = '0;
      cpu_bus.wdata = '0;
      repeat (3) step();
      check_rst("rst_");
      reset = 1'b0;
      step();

      // Write 0x1234 <= 0xA5, then read it back.
      cpu_op(1'b1, 16'h1234, 8'hA5, 8'h00, 1);
      check("wr_ram_we", ram_we, 1);
      check("wr_ram_addr", ram_addr, 16'h1234);
      check("wr_ram_wdata", ram_wdata, 8'hA5);
      step();
      cpu_op(1'b0, 16'h1234, 8'h00, 8'hA5, 2);
      step();

      // 256 back-to-back fetches with a CPU write waiting throughout.
      fork
         vid_burst(256, 16'h0000);
         cpu_op(1'b1, 16'h4000, 8'h77, 8'h00, 257);
      join
      step();
      vblank_pulse("stall_max_saturated", 8'd255);

      // Video and CPU reads alternate every cycle.
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) begin
            vid_req     = 1'b1;
            vid_addr    = 16'h0100 + 16'(i);
            cpu_bus.req = 1'b0;
            push_vid(vid_addr);
         end else begin
            vid_req      = 1'b0;
            cpu_bus.req  = 1'b1;
            cpu_bus.we   = 1'b0;
            cpu_bus.addr = 16'h0200 + 16'(i);
            ce.cyc  = cyc + 2;
            ce.data = mem[cpu_bus.addr];
            ce.rd   = 1'b1;
            cpu_q.push_back(ce);
         end
         step();
      end
      vid_req     = 1'b0;
      cpu_bus.req = 1'b0;
      repeat (4) step();
      check("alt_cpu_pending", cpu_q.size(), 0);
      check("alt_vid_pending", vid_q.size(), 0);

      // 37-cycle stall in one frame, none in the next.
      fork
         vid_burst(37, 16'h0300);
         cpu_op(1'b1, 16'h4001, 8'h11, 8'h00, 38);
      join
      step();
      vblank_pulse("stall_max_37", 8'd37);
      cpu_op(1'b1, 16'h4002, 8'h22, 8'h00, 1);
      step();
      vblank_pulse("stall_max_zero", 8'd0);

      // Request withdrawn before grant: no ack, no write.
      pre_4004      = mem[16'h4004];
      vid_req       = 1'b1;
      vid_addr      = 16'h0010;
      push_vid(vid_addr);
      cpu_bus.req   = 1'b1;
      cpu_bus.we    = 1'b1;
      cpu_bus.addr  = 16'h4004;
      cpu_bus.wdata = 8'hEE;
      step();
      vid_addr = 16'h0011;
      push_vid(vid_addr);
      step();
      vid_req     = 1'b0;
      cpu_bus.req = 1'b0;
      repeat (4) step();
      check("withdraw_no_write", mem[16'h4004], pre_4004);
      vblank_pulse("stall_max_withdrawn", 8'd2);

      // Reset one cycle after a read grant discards the read.
      cpu_bus.req  = 1'b1;
      cpu_bus.we   = 1'b0;
      cpu_bus.addr = 16'h1234;
      step();
      reset       = 1'b1;
      cpu_bus.req = 1'b0;
      step();
      check_rst("midrst_");
      step();
      reset = 1'b0;
      repeat (5) step();
      cpu_op(1'b0, 16'h1234, 8'h00, 8'hA5, 2);
      step();

`ifdef VRAM_BLANK_ONLY_EN
      // Active display holds the CPU off until the first hblank cycle.
      hblank = 1'b0;
      fork
         begin
            repeat (5) step();
            hblank = 1'b1;
         end
         cpu_op(1'b1, 16'h4003, 8'h33, 8'h00, 6);
      join
      hblank = HB_REST;
      step();
`endif

      repeat (4) step();
      check("vid_missing", vid_q.size(), 0);
      check("cpu_missing", cpu_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
